// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 1-cycle-latency RAM.
// Grant is held while the owner streams or locks, capped at MAX_HOLD beats when the peer waits.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int DEPTH    = 5000,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  input  logic              a_lock,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  input  logic              b_lock,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              overflow_err,
  output logic [1:0]        dbg_state
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

  state_t          state;
  state_t          peer_state;
  logic            last_owner;  // 0 = A, 1 = B
  logic [HC_W-1:0] hold_cnt;
  logic [HC_W-1:0] hold_nxt;
  logic            rd_pend, rd_tag, rd_oor;

  logic              own_a, own_b, a_req, b_req;
  logic              x_read, x_write, x_req, x_lock, peer_req;
  logic [ADDR_W-1:0] x_addr;
  logic [BE_W-1:0]   x_be;
  logic [DATA_W-1:0] x_wd;
  logic              acc, in_range, rd_acc;
  logic [DATA_W-1:0] rdata_ret;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);
  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  always_comb begin
    if (own_b) begin
      x_read   = b_read;
      x_write  = b_write;
      x_addr   = b_address;
      x_be     = b_byteenable;
      x_wd     = b_writedata;
      x_lock   = b_lock;
      peer_req = a_req;
    end else begin
      x_read   = a_read;
      x_write  = a_write;
      x_addr   = a_address;
      x_be     = a_byteenable;
      x_wd     = a_writedata;
      x_lock   = a_lock;
      peer_req = b_req;
    end
  end

  // Handshake: a beat transfers in the cycle where (read|write) && !waitrequest;
  // only the current owner ever sees waitrequest low, and read data returns one
  // cycle after its beat with readdatavalid on the port that issued it.
  assign x_req      = x_read | x_write;
  assign acc        = (own_a & a_req) | (own_b & b_req);
  assign in_range   = ({1'b0, x_addr} < DEPTH_W);
  assign rd_acc     = acc & x_read & ~x_write;
  assign hold_nxt   = (acc && hold_cnt != HOLD_MAX) ? hold_cnt + HC_W'(1) : hold_cnt;
  assign peer_state = own_b ? OWN_A : OWN_B;

  assign mem_address    = x_addr;
  assign mem_byteenable = x_be;
  assign mem_writedata  = x_wd;
  assign mem_chipselect = acc & in_range;
  assign mem_write      = acc & in_range & x_write;

  assign a_waitrequest = ~own_a;
  assign b_waitrequest = ~own_b;
  assign dbg_state     = state;

  // Out-of-range reads never touched the RAM, so their return is forced to zero.
  assign rdata_ret       = rd_oor ? '0 : mem_readdata;
  assign a_readdatavalid = rd_pend & ~rd_tag;
  assign b_readdatavalid = rd_pend & rd_tag;
  assign a_readdata      = a_readdatavalid ? rdata_ret : '0;
  assign b_readdata      = b_readdatavalid ? rdata_ret : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_owner   <= 1'b1;
      hold_cnt     <= '0;
      rd_pend      <= 1'b0;
      rd_tag       <= 1'b0;
      rd_oor       <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      rd_pend <= rd_acc;
      rd_tag  <= own_b;
      rd_oor  <= ~in_range;
      if (acc && !in_range) overflow_err <= 1'b1;
      case (state)
        IDLE: begin
          if (a_req && b_req) state <= last_owner ? OWN_A : OWN_B;
          else if (a_req)     state <= OWN_A;
          else if (b_req)     state <= OWN_B;
        end
        OWN_A, OWN_B: begin
          if (!x_req && !x_lock) begin
            state      <= peer_req ? peer_state : IDLE;
            hold_cnt   <= '0;
            last_owner <= own_b;
          end else if (!x_lock && peer_req && hold_nxt == HOLD_MAX) begin
            state      <= peer_state;
            hold_cnt   <= '0;
            last_owner <= own_b;
          end else begin
            hold_cnt <= hold_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM fixture, per-port drivers, return-data
// scoreboard with a reference memory, and grant-order logging.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 5000;

  logic              clk;
  logic              reset;
  logic              a_read, a_write, a_lock, b_read, b_write, b_lock;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [BE_W-1:0]   a_byteenable, b_byteenable;
  logic [DATA_W-1:0] a_writedata, b_writedata;
  logic              a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
  logic [DATA_W-1:0] a_readdata, b_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              overflow_err;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  logic              grant_q[$];
  int                grant_cyc_q[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] ram [0:8191];
  logic              exp_rv_a, exp_rv_b, exp_ovf;
  logic [DATA_W-1:0] last_a_rdata, last_b_rdata;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_lock(a_lock),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_lock(b_lock),
    .b_waitrequest(b_waitrequest), .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .overflow_err(overflow_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // RAM fixture: 8192 physical words so a leaked out-of-range write is visible
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int i = 0; i < BE_W; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Scoreboard / monitor
  always @(negedge clk) begin : mon
    logic              acc_a, acc_b, port, wr, rd, inr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd, ed;
    if (reset) begin
      exp_rv_a = 1'b0;
      exp_rv_b = 1'b0;
      exp_ovf  = 1'b0;
      exp_a_q.delete();
      exp_b_q.delete();
    end else begin
      checks++;
      if (overflow_err !== exp_ovf) begin
        errors++;
        $display("FAIL overflow_err: got %b want %b (cyc %0d)", overflow_err, exp_ovf, cyc);
      end
      if (a_readdatavalid || exp_rv_a) begin
        checks++;
        if (a_readdatavalid !== exp_rv_a) begin
          errors++;
          $display("FAIL a_readdatavalid: got %b want %b (cyc %0d)", a_readdatavalid, exp_rv_a, cyc);
        end
      end
      if (b_readdatavalid || exp_rv_b) begin
        checks++;
        if (b_readdatavalid !== exp_rv_b) begin
          errors++;
          $display("FAIL b_readdatavalid: got %b want %b (cyc %0d)", b_readdatavalid, exp_rv_b, cyc);
        end
      end
      if (a_readdatavalid === 1'b1 && exp_a_q.size() > 0) begin
        ed = exp_a_q.pop_front();
        last_a_rdata = a_readdata;
        checks++;
        if (a_readdata !== ed || b_readdata !== '0) begin
          errors++;
          $display("FAIL a_readdata: got %h (b %h) want %h (b 0)", a_readdata, b_readdata, ed);
        end
      end
      if (b_readdatavalid === 1'b1 && exp_b_q.size() > 0) begin
        ed = exp_b_q.pop_front();
        last_b_rdata = b_readdata;
        checks++;
        if (b_readdata !== ed || a_readdata !== '0) begin
          errors++;
          $display("FAIL b_readdata: got %h (a %h) want %h (a 0)", b_readdata, a_readdata, ed);
        end
      end
      exp_rv_a = 1'b0;
      exp_rv_b = 1'b0;
      acc_a = (a_read | a_write) & ~a_waitrequest;
      acc_b = (b_read | b_write) & ~b_waitrequest;
      if (acc_a && acc_b) begin
        checks++;
        errors++;
        $display("FAIL dual_accept: got both ports accepted want one (cyc %0d)", cyc);
      end
      if (acc_a || acc_b) begin
        port = acc_b;
        addr = port ? b_address : a_address;
        wr   = port ? b_write : a_write;
        rd   = port ? b_read : a_read;
        be   = port ? b_byteenable : a_byteenable;
        wd   = port ? b_writedata : a_writedata;
        grant_q.push_back(port);
        grant_cyc_q.push_back(cyc);
        inr = (int'(addr) < DEPTH);
        checks++;
        if (mem_chipselect !== inr || mem_write !== (inr & wr) || (inr && mem_address !== addr)) begin
          errors++;
          $display("FAIL mem_bus: got cs=%b we=%b addr=%h want cs=%b we=%b addr=%h",
                   mem_chipselect, mem_write, mem_address, inr, inr & wr, addr);
        end
        if (!inr) exp_ovf = 1'b1;
        if (wr) begin
          if (inr)
            for (int i = 0; i < BE_W; i++)
              if (be[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
        end else if (rd) begin
          ed = inr ? ref_mem[addr] : '0;
          if (port) begin exp_b_q.push_back(ed); exp_rv_b = 1'b1; end
          else      begin exp_a_q.push_back(ed); exp_rv_a = 1'b1; end
        end
      end else begin
        checks++;
        if (mem_chipselect !== 1'b0) begin
          errors++;
          $display("FAIL mem_idle: got chipselect %b want 0 (cyc %0d)", mem_chipselect, cyc);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_port(input bit port);
    if (port) begin b_read = 1'b0; b_write = 1'b0; end
    else      begin a_read = 1'b0; a_write = 1'b0; end
  endtask

  task automatic do_beat(input bit port, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] data);
    bit done = 1'b0;
    if (port) begin
      b_read = ~wr; b_write = wr; b_address = addr; b_byteenable = be; b_writedata = data;
    end else begin
      a_read = ~wr; a_write = wr; a_address = addr; a_byteenable = be; a_writedata = data;
    end
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = port ? ~b_waitrequest : ~a_waitrequest;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: port %0d got stalled want accepted within 200 cycles", port);
    end
  endtask

  task automatic stream(input bit port, input int n, input logic [ADDR_W-1:0] base);
    for (int i = 0; i < n; i++) do_beat(port, 1'b1, base + ADDR_W'(i), 4'hF, $urandom);
    idle_port(port);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    wait_cycles(3);
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d/%0d outstanding returns want 0/0", name, exp_a_q.size(), exp_b_q.size());
    end
  endtask

  task automatic check_seq(input string name, input logic exp_seq[$]);
    int bad = -1;
    for (int i = 0; i < exp_seq.size() && i < grant_q.size(); i++)
      if (bad < 0 && grant_q[i] !== exp_seq[i]) bad = i;
    checks++;
    if (grant_q.size() != exp_seq.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d grants (first bad idx %0d) want %0d grants in order", name, grant_q.size(), bad, exp_seq.size());
    end
  endtask

  // Tests
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: got %b%b want 11", a_waitrequest, b_waitrequest);
    end
    checks++;
    if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0 || a_readdata !== '0 || b_readdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got rv=%b%b a=%h b=%h want 00/0/0", a_readdatavalid, b_readdatavalid, a_readdata, b_readdata);
    end
    checks++;
    if (overflow_err !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got ovf=%b cs=%b we=%b want 000", overflow_err, mem_chipselect, mem_write);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    last_a_rdata = 'x;
    do_beat(1'b0, 1'b1, 13'h010, 4'hF, 32'h1234_5678);
    do_beat(1'b0, 1'b0, 13'h010, 4'hF, 32'h0);
    idle_port(1'b0);
    wait_cycles(3);
    checks++;
    if (last_a_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_read: got %h want 12345678", last_a_rdata);
    end
    check_drained("write_read");
  endtask

  task automatic test_simul_req();
    logic exp_seq[$];
    apply_reset();
    grant_q.delete();
    grant_cyc_q.delete();
    fork
      begin do_beat(1'b0, 1'b1, 13'h100, 4'hF, $urandom); idle_port(1'b0); end
      begin do_beat(1'b1, 1'b1, 13'h101, 4'hF, $urandom); idle_port(1'b1); end
    join
    exp_seq = '{1'b0, 1'b1};
    check_seq("simul_order", exp_seq);
    checks++;
    if (grant_cyc_q.size() != 2 || grant_cyc_q[1] - grant_cyc_q[0] != 2) begin
      errors++;
      $display("FAIL simul_gap: got %0d grants, cycle delta %0d want 2",
               grant_cyc_q.size(), grant_cyc_q.size() == 2 ? grant_cyc_q[1] - grant_cyc_q[0] : -1);
    end
    wait_cycles(2);
  endtask

  task automatic test_max_hold();
    logic exp_seq[$];
    int   runs[5] = '{8, 8, 8, 4, 4};
    grant_q.delete();
    fork
      stream(1'b0, 20, 13'h200);
      begin wait_cycles(2); stream(1'b1, 12, 13'h300); end
    join
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < runs[r]; i++) exp_seq.push_back(r % 2 == 1);
    check_seq("max_hold_order", exp_seq);
    wait_cycles(2);
  endtask

  task automatic test_lock();
    logic exp_seq[$];
    grant_q.delete();
    a_lock = 1'b1;
    fork
      begin
        stream(1'b0, 20, 13'h400);
        wait_cycles(3);
        checks++;
        if (b_waitrequest !== 1'b1 || dbg_state !== 2'd1) begin
          errors++;
          $display("FAIL lock_hold: got b_wait=%b state=%0d want 1/1", b_waitrequest, dbg_state);
        end
        a_lock = 1'b0;
      end
      begin wait_cycles(2); stream(1'b1, 4, 13'h500); end
    join
    for (int i = 0; i < 24; i++) exp_seq.push_back(i >= 20);
    check_seq("lock_order", exp_seq);
    wait_cycles(2);
  endtask

  task automatic test_out_of_range();
    logic [DATA_W-1:0] d;
    d = $urandom;
    last_b_rdata = 'x;
    do_beat(1'b1, 1'b1, 13'd4999, 4'hF, d);
    do_beat(1'b1, 1'b0, 13'd4999, 4'hF, 32'h0);
    idle_port(1'b1);
    wait_cycles(2);
    checks++;
    if (last_b_rdata !== d || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_last_word: got %h ovf=%b want %h ovf=0", last_b_rdata, overflow_err, d);
    end
    do_beat(1'b1, 1'b0, 13'd5000, 4'hF, 32'h0);
    do_beat(1'b1, 1'b1, 13'd5000, 4'hF, 32'hDEAD_BEEF);
    idle_port(1'b1);
    wait_cycles(3);
    checks++;
    if (last_b_rdata !== 32'h0 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got %h ovf=%b want 00000000 ovf=1", last_b_rdata, overflow_err);
    end
    checks++;
    if (ram[5000] !== 32'h0) begin
      errors++;
      $display("FAIL oor_ram_untouched: got %h want 00000000", ram[5000]);
    end
    check_drained("oor");
  endtask

  task automatic test_byte_write();
    last_a_rdata = 'x;
    do_beat(1'b0, 1'b1, 13'h020, 4'hF, 32'h0);
    do_beat(1'b0, 1'b1, 13'h020, 4'b0010, 32'hFFFF_FFFF);
    do_beat(1'b0, 1'b0, 13'h020, 4'hF, 32'h0);
    idle_port(1'b0);
    wait_cycles(3);
    checks++;
    if (last_a_rdata !== 32'h0000_FF00) begin
      errors++;
      $display("FAIL byte_write: got %h want 0000ff00", last_a_rdata);
    end
    check_drained("byte_write");
  endtask

  task automatic test_reset_mid();
    do_beat(1'b0, 1'b0, 13'h010, 4'hF, 32'h0);
    reset = 1'b1;
    idle_port(1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_rdv: got %b%b want 00", a_readdatavalid, b_readdatavalid);
      end
      checks++;
      if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_mid_fsm: got wait=%b%b state=%0d want 11/0", a_waitrequest, b_waitrequest, dbg_state);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_drained("reset_mid");
  endtask

  initial begin
    reset = 1'b1;
    a_read = 1'b0; a_write = 1'b0; a_lock = 1'b0; a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_read = 1'b0; b_write = 1'b0; b_lock = 1'b0; b_address = '0; b_byteenable = '0; b_writedata = '0;
    mem_readdata = '0;
    exp_rv_a = 1'b0; exp_rv_b = 1'b0; exp_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8192; i++) ram[i] = '0;
    test_reset();
    test_write_read();
    test_simul_req();
    test_max_hold();
    test_lock();
    test_out_of_range();
    test_byte_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
